// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer.
//   state_t        : keyer FSM states
//   *_DEF          : default unit lengths (in tick units)
//   CNT_W          : unit counter width, sized to hold the largest gap length
package morse_pkg;

  localparam int DOT_UNITS_DEF  = 1;
  localparam int DASH_UNITS_DEF = 3;
  localparam int SYM_GAP_DEF    = 1;
  localparam int CHAR_GAP_DEF   = 3;
  localparam int WORD_GAP_DEF   = 7;

  localparam int CNT_W = $clog2(WORD_GAP_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    MARK,
    SPACE,
    CGAP
  } state_t;

endpackage

// File: rtl/morse_keyer_if.sv
// Bundle between the keyer, its upstream character source, the external
// code register and the tick generator.
//   master : the environment (character source + code register + tick)
//   slave  : the keyer itself
interface morse_keyer_if;
  import morse_pkg::*;

  logic             char_valid;
  logic             char_ready;
  logic             char_load;
  logic             shft_cnt;
  logic             shft_data;
  logic [3:0]       cntr_data;
  logic             tick;
  logic             key_out;
  logic             busy;

  modport master (
    output char_valid, shft_data, cntr_data, tick,
    input  char_ready, char_load, shft_cnt, key_out, busy
  );

  modport slave (
    input  char_valid, shft_data, cntr_data, tick,
    output char_ready, char_load, shft_cnt, key_out, busy
  );

endinterface

// File: rtl/morse_unit_cnt.sv
// Unit-time down counter for the keyer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over counting)
//   load_val   : number of ticks the next state should last
//   en         : counting enabled (keyer in a timed state)
//   tick       : one-clock unit-time pulse
//   done       : last tick of the current timed state
module morse_unit_cnt
  import morse_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Exiting on the tick that sees count==1 makes a state last exactly N ticks.
  assign done = en & tick & (count_reg == CNT_W'(1));

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: turns a code/length pair held in an external shift register
// into timed key-on (mark) and key-off (space/gap) periods.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of morse_keyer_if
//                char_valid/char_ready/char_load : character handshake
//                shft_cnt/shft_data/cntr_data    : code register control/status
//                tick                            : unit-time enable
//                key_out                         : registered key enable
//                busy                            : keyer not idle
module morse_keyer
  import morse_pkg::*;
#(
  parameter int DOT_UNITS  = DOT_UNITS_DEF,
  parameter int DASH_UNITS = DASH_UNITS_DEF,
  parameter int SYM_GAP    = SYM_GAP_DEF,
  parameter int CHAR_GAP   = CHAR_GAP_DEF,
  parameter int WORD_GAP   = WORD_GAP_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  morse_keyer_if.slave bus
);

  state_t           state_reg, state_next;
  logic             first_reg, first_next;
  logic             key_reg;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_en;
  logic             cnt_done;
  logic             load;
  logic             shft;

  assign bus.char_ready = (state_reg == IDLE);
  assign load           = bus.char_valid & (state_reg == IDLE);
  assign bus.char_load  = load;
  assign bus.shft_cnt   = shft;
  assign bus.key_out    = key_reg;
  assign bus.busy       = (state_reg != IDLE);

  // Ticks only count in the timed states; EVAL is always a single clock.
  assign cnt_en = (state_reg == MARK) || (state_reg == SPACE) || (state_reg == CGAP);

  morse_unit_cnt u_unit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tick     (bus.tick),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      first_reg <= 1'b0;
      key_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      first_reg <= first_next;
      // Registered from the next state so key_out is high exactly in MARK.
      key_reg   <= (state_next == MARK);
    end
  end

  always_comb begin
    state_next = state_reg;
    first_next = first_reg;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    shft       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = EVAL;
          first_next = 1'b1;
        end
      end
      EVAL: begin
        cnt_load = 1'b1;
        if (bus.cntr_data != 4'd0) begin
          state_next = MARK;
          cnt_val    = bus.shft_data ? CNT_W'(DASH_UNITS) : CNT_W'(DOT_UNITS);
        end else begin
          state_next = CGAP;
          // A zero-length character is a word space; the previous character
          // already supplied CHAR_GAP of it.
          cnt_val    = first_reg ? CNT_W'(WORD_GAP - CHAR_GAP)
                                 : CNT_W'(CHAR_GAP - SYM_GAP);
        end
      end
      MARK: begin
        if (cnt_done) begin
          state_next = SPACE;
          first_next = 1'b0;
          shft       = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(SYM_GAP);
        end
      end
      SPACE: begin
        if (cnt_done) state_next = EVAL;
      end
      CGAP: begin
        if (cnt_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_keyer.sv
module tb_morse_keyer;
  import morse_pkg::*;

  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  morse_keyer_if bus();

  morse_keyer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External code register: loads on char_load, shifts left on shft_cnt.
  logic [7:0] code_in  = 8'h00;
  logic [3:0] len_in   = 4'h0;
  logic [7:0] code_reg = 8'h00;
  logic [3:0] cnt_reg  = 4'h0;

  assign bus.shft_data = code_reg[7];
  assign bus.cntr_data = cnt_reg;

  always @(posedge clk) begin
    if (bus.char_load) begin
      code_reg <= code_in;
      cnt_reg  <= len_in;
    end else if (bus.shft_cnt) begin
      code_reg <= code_reg << 1;
      cnt_reg  <= cnt_reg - 4'd1;
    end
  end

  int checks = 0;
  int errors = 0;

  bit tk[MAXC];
  bit exp_key[MAXC];
  bit exp_busy[MAXC];
  bit exp_shft[MAXC];

  task automatic check_value(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Cycle index at which the n-th tick (counting from cycle 'start') occurs.
  function automatic int seg_end(input int start, input int n);
    int seen = 0;
    for (int j = start; j < MAXC; j++) begin
      if (tk[j]) seen++;
      if (seen == n) return j;
    end
    return MAXC - 1;
  endfunction

  // Reference timeline: cycle 0 is the load cycle, each symbol is one
  // evaluation cycle, a mark of dot/dash ticks, then a symbol gap; the
  // character ends with one evaluation cycle and the remaining gap.
  // Returns the index of the first idle cycle.
  function automatic int build_model(input logic [7:0] code, input logic [3:0] len);
    int c;
    int e;
    int units;
    for (int k = 0; k < MAXC; k++) begin
      exp_key[k] = 0; exp_busy[k] = 0; exp_shft[k] = 0;
    end
    c = 1;
    for (int i = 0; i < int'(len); i++) begin
      exp_busy[c] = 1;
      c++;
      units = (i < 8 && code[7-i]) ? DASH_UNITS_DEF : DOT_UNITS_DEF;
      e = seg_end(c, units);
      for (int j = c; j <= e; j++) begin exp_key[j] = 1; exp_busy[j] = 1; end
      exp_shft[e] = 1;
      c = e + 1;
      e = seg_end(c, SYM_GAP_DEF);
      for (int j = c; j <= e; j++) exp_busy[j] = 1;
      c = e + 1;
      if (c >= MAXC - 64) return c;
    end
    exp_busy[c] = 1;
    c++;
    units = (len == 4'd0) ? (WORD_GAP_DEF - CHAR_GAP_DEF) : (CHAR_GAP_DEF - SYM_GAP_DEF);
    e = seg_end(c, units);
    for (int j = c; j <= e; j++) exp_busy[j] = 1;
    return e + 1;
  endfunction

  // mode 0: tick every clock, 1: tick every 4th clock, 2: random ticks
  task automatic run_char(input string name, input logic [7:0] code, input logic [3:0] len,
                          input int mode, input bit hold);
    int n_cyc;
    for (int k = 0; k < MAXC; k++) begin
      case (mode)
        0:       tk[k] = 1;
        1:       tk[k] = (k % 4 == 3);
        default: tk[k] = ($urandom_range(0, 1) == 1);
      endcase
    end
    n_cyc = build_model(code, len);
    code_in = code;
    len_in  = len;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk);
      #1;
      bus.tick       = tk[k];
      bus.char_valid = (k == 0) || hold;
      #1;
      check_value({name, ".key_out"},    int'(bus.key_out),    int'(exp_key[k]));
      check_value({name, ".busy"},       int'(bus.busy),       int'(exp_busy[k]));
      check_value({name, ".shft_cnt"},   int'(bus.shft_cnt),   int'(exp_shft[k]));
      check_value({name, ".char_ready"}, int'(bus.char_ready), int'(!exp_busy[k]));
      check_value({name, ".char_load"},  int'(bus.char_load),  (k == 0) ? 1 : 0);
    end
    $display("char %s code=%02h len=%0d tick_mode=%0d hold=%0d cycles=%0d",
             name, code, len, mode, hold, n_cyc);
  endtask

  task automatic idle_check(input string name);
    @(posedge clk);
    #1;
    bus.tick       = 1'b1;
    bus.char_valid = 1'b0;
    #1;
    check_value({name, ".idle_ready"}, int'(bus.char_ready), 1);
    check_value({name, ".idle_busy"},  int'(bus.busy),       0);
    check_value({name, ".idle_key"},   int'(bus.key_out),    0);
    check_value({name, ".idle_shft"},  int'(bus.shft_cnt),   0);
    check_value({name, ".idle_load"},  int'(bus.char_load),  0);
  endtask

  initial begin
    bus.char_valid = 1'b0;
    bus.tick       = 1'b0;

    // During reset
    #1;
    check_value("rst.char_ready", int'(bus.char_ready), 1);
    check_value("rst.busy",       int'(bus.busy),       0);
    check_value("rst.key_out",    int'(bus.key_out),    0);
    check_value("rst.shft_cnt",   int'(bus.shft_cnt),   0);
    check_value("rst.load_lo",    int'(bus.char_load),  0);
    bus.char_valid = 1'b1;
    #1;
    check_value("rst.load_hi",    int'(bus.char_load),  1);
    bus.char_valid = 1'b0;
    #20;
    rst_n = 1'b1;
    $display("reset released at t=%0t", $time);

    run_char("A", 8'b0100_0000, 4'd2, 0, 1'b0);
    idle_check("A");
    run_char("space", 8'h00, 4'd0, 0, 1'b0);
    idle_check("space");
    run_char("E", 8'h00, 4'd1, 1, 1'b0);
    idle_check("E");

    // Held char_valid: only one load, then a second in the first idle cycle.
    run_char("T_hold1", 8'b1000_0000, 4'd1, 0, 1'b1);
    run_char("T_hold2", 8'b1000_0000, 4'd1, 0, 1'b0);
    idle_check("T_hold");

    // Reset in the middle of a dash.
    @(posedge clk);
    #1;
    code_in = 8'b1000_0000; len_in = 4'd1;
    bus.tick = 1'b1; bus.char_valid = 1'b1;
    #1;
    check_value("T_rst.load", int'(bus.char_load), 1);
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    #1;
    check_value("T_rst.eval_busy", int'(bus.busy), 1);
    @(posedge clk);
    #2;
    check_value("T_rst.mark_key", int'(bus.key_out), 1);
    rst_n = 1'b0;
    #1;
    check_value("T_rst.key_out",    int'(bus.key_out),    0);
    check_value("T_rst.char_ready", int'(bus.char_ready), 1);
    check_value("T_rst.busy",       int'(bus.busy),       0);
    check_value("T_rst.shft_cnt",   int'(bus.shft_cnt),   0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-dash applied and released at t=%0t", $time);
    run_char("T_after_rst", 8'b1000_0000, 4'd1, 0, 1'b0);
    idle_check("T_after_rst");

    // Randomized characters, including lengths beyond 8 symbols.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rc;
      logic [3:0] rl;
      rc = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      run_char($sformatf("rnd%0d", n), rc, rl, int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0));
    end
    idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
